// File: rtl/threshold_monitor.sv
// threshold_monitor: sampled threshold alarm with hysteresis and persistence.
// Optional STICKY_ALARM_EN: alarm latches in HIGH until the clr strobe.
module threshold_monitor #(
    parameter int WIDTH   = 5,
    parameter int PERSIST = 3,
    parameter int EVT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_valid,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] H,
`ifdef STICKY_ALARM_EN
    input  logic             clr,
`endif
    output logic             L,
    output logic             L_rise,
    output logic             L_fall,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int CW = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
    localparam logic [CW-1:0] P_LAST = CW'(PERSIST);

    typedef enum logic [1:0] {
        LOW,
        ARM,
        HIGH,
        DISARM
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             l_q, l_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [EVT_W-1:0] evt_q, evt_d;

    logic [WIDTH:0]   clr_thr;
    logic             set_c;
    logic             clear_c;
    logic [CW-1:0]    cnt_inc;

    // Qualifying-sample conditions; a band wider than A disables clearing.
    always_comb begin
        clr_thr = {1'b0, A} - {1'b0, H};
        set_c   = (D >= A);
        clear_c = (H <= A) && ({1'b0, D} < clr_thr);
        cnt_inc = cnt_q + CW'(1);
    end

`ifdef STICKY_ALARM_EN
    logic unused_clear;
    assign unused_clear = clear_c;
`endif

    // Next state and persistence counter; only valid samples advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (D_valid) begin
            unique case (state_q)
                LOW: begin
                    if (set_c) begin
                        if (PERSIST == 1) begin
                            state_d = HIGH;
                            cnt_d   = '0;
                        end else begin
                            state_d = ARM;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ARM: begin
                    if (set_c) begin
                        if (cnt_inc == P_LAST) begin
                            state_d = HIGH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end
                end
                HIGH: begin
`ifndef STICKY_ALARM_EN
                    if (clear_c) begin
                        if (PERSIST == 1) begin
                            state_d = LOW;
                            cnt_d   = '0;
                        end else begin
                            state_d = DISARM;
                            cnt_d   = CW'(1);
                        end
                    end
`endif
                end
                DISARM: begin
                    if (clear_c) begin
                        if (cnt_inc == P_LAST) begin
                            state_d = LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            endcase
        end
`ifdef STICKY_ALARM_EN
        if (clr) begin
            state_d = LOW;
            cnt_d   = '0;
        end
`endif
    end

    // Alarm level, edge pulses and saturating rising-event counter.
    always_comb begin
        l_d    = (state_d == HIGH) || (state_d == DISARM);
        rise_d = l_d && !l_q;
        fall_d = !l_d && l_q;
        evt_d  = evt_q;
        if (rise_d && (evt_q != {EVT_W{1'b1}})) begin
            evt_d = evt_q + EVT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
            l_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    assign L       = l_q;
    assign L_rise  = rise_q;
    assign L_fall  = fall_q;
    assign evt_cnt = evt_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// tb_threshold_monitor: directed scoreboard bench for threshold_monitor.
// Define STICKY_ALARM_EN to exercise the sticky-alarm build.
module tb_threshold_monitor;

    localparam int P = 3;
`ifdef STICKY_ALARM_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct {
        logic       l;
        logic       rise;
        logic       fall;
        logic [7:0] evt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_valid;
    logic [4:0] D;
    logic [4:0] A;
    logic [4:0] H;
    logic       clr;
    logic       L;
    logic       L_rise;
    logic       L_fall;
    logic [7:0] evt_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic       m_l;
    int         m_run;
    int         m_evt;

    threshold_monitor #(.WIDTH(5), .PERSIST(P), .EVT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .D_valid (D_valid),
        .D       (D),
        .A       (A),
        .H       (H),
`ifdef STICKY_ALARM_EN
        .clr     (clr),
`endif
        .L       (L),
        .L_rise  (L_rise),
        .L_fall  (L_fall),
        .evt_cnt (evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic [4:0] d,
                         input logic c, output exp_t e);
        logic old;
        logic qual;
        old = m_l;
        if (STK && c) begin
            m_l   = 1'b0;
            m_run = 0;
        end else if (v) begin
            if (!m_l) qual = (d >= A);
            else if (STK) qual = 1'b0;
            else if (H <= A) qual = (int'(d) + int'(H) < int'(A));
            else qual = 1'b0;
            m_run = qual ? m_run + 1 : 0;
            if (m_run == P) begin
                m_l   = !m_l;
                m_run = 0;
                if (m_l && m_evt < 255) m_evt++;
            end
        end
        e.l    = m_l;
        e.rise = m_l && !old;
        e.fall = !m_l && old;
        e.evt  = 8'(m_evt);
    endtask

    task automatic step(input logic v, input logic [4:0] d,
                        input logic c = 1'b0);
        exp_t e;
        @(negedge clk);
        D_valid = v;
        D       = d;
        clr     = c;
        model(v, d, c, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("L", 32'(L), 32'(e.l));
            chk("L_rise", 32'(L_rise), 32'(e.rise));
            chk("L_fall", 32'(L_fall), 32'(e.fall));
            chk("evt_cnt", 32'(evt_cnt), 32'(e.evt));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        D_valid = 1'b0;
        clr     = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_L", 32'(L), 32'd0);
        chk("rst_rise", 32'(L_rise), 32'd0);
        chk("rst_fall", 32'(L_fall), 32'd0);
        chk("rst_evt", 32'(evt_cnt), 32'd0);
        m_l   = 1'b0;
        m_run = 0;
        m_evt = 0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic go_low();
        if (STK) begin
            step(1'b0, 5'd0, 1'b1);
        end else begin
            repeat (3) step(1'b1, 5'd0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        D_valid = 1'b0;
        D       = '0;
        A       = 5'd25;
        H       = 5'd3;
        clr     = 1'b0;
        m_l     = 1'b0;
        m_run   = 0;
        m_evt   = 0;
        do_reset();

        repeat (3) step(1'b1, 5'd25);
        chk("s1_L", 32'(L), 32'd1);
        chk("s1_evt", 32'(evt_cnt), 32'd1);

        step(1'b1, 5'd23);
        step(1'b1, 5'd22);
        repeat (3) step(1'b1, 5'd21);
        chk("s3_L", 32'(L), STK ? 32'd1 : 32'd0);
        go_low();

        step(1'b1, 5'd25);
        step(1'b1, 5'd24);
        step(1'b1, 5'd25);
        step(1'b1, 5'd25);
        chk("s2_L", 32'(L), 32'd0);
        chk("s2_evt", 32'(evt_cnt), 32'd1);
        go_low();

        step(1'b1, 5'd25);
        step(1'b1, 5'd25);
        do_reset();
        step(1'b1, 5'd25);
        step(1'b1, 5'd25);
        chk("s4_L0", 32'(L), 32'd0);
        step(1'b1, 5'd25);
        chk("s4_L1", 32'(L), 32'd1);
        go_low();

        step(1'b1, 5'd25);
        step(1'b0, 5'd25);
        step(1'b1, 5'd25);
        step(1'b0, 5'd25);
        chk("s5_L0", 32'(L), 32'd0);
        step(1'b1, 5'd25);
        chk("s5_L1", 32'(L), 32'd1);
        go_low();

        A = 5'd2;
        H = 5'd5;
        repeat (3) step(1'b1, 5'd2);
        repeat (4) step(1'b1, 5'd0);
        chk("wide_band_L", 32'(L), 32'd1);
        A = 5'd25;
        H = 5'd3;
        go_low();

`ifdef STICKY_ALARM_EN
        do_reset();
        repeat (3) step(1'b1, 5'd25);
        repeat (5) step(1'b1, 5'd0);
        chk("s6_hold", 32'(L), 32'd1);
        step(1'b1, 5'd0, 1'b1);
        chk("s6_clr", 32'(L), 32'd0);
        repeat (3) step(1'b1, 5'd25);
        chk("s6_L", 32'(L), 32'd1);
        chk("s6_evt", 32'(evt_cnt), 32'd2);
        go_low();
        step(1'b1, 5'd25);
        step(1'b1, 5'd25);
        step(1'b1, 5'd25, 1'b1);
        step(1'b1, 5'd25);
        chk("clr_wins", 32'(L), 32'd0);
        go_low();
`endif

        for (int i = 0; i < 260; i++) begin
            repeat (3) step(1'b1, 5'd25);
            go_low();
        end
        chk("evt_sat", 32'(evt_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/threshold_monitor.md
# threshold_monitor

- Sampled threshold alarm with hysteresis and persistence filtering.
- Compares a WIDTH-bit reading `D` against a programmable threshold `A`. `L` asserts only after PERSIST consecutive qualifying samples, and deasserts only after PERSIST consecutive samples below `A - H`.
- Sits between the sensor/ADC sample path and the display/alarm logic. It is the clocked, parametrised successor of the combinational `D`-vs-`A` comparator.

## Interface
Parameters:
- WIDTH, 5, width of `D`, `A`, `H`.
- PERSIST, 3, consecutive qualifying valid samples required for each transition; ≥1.
- EVT_W, 8, width of the alarm event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- D_valid  in  1  `D` carries a new sample this cycle.
- D  in  WIDTH  unsigned reading.
- A  in  WIDTH  unsigned set threshold.
- H  in  WIDTH  unsigned hysteresis band.
- clr  in  1  alarm clear strobe; present only with STICKY_ALARM_EN.
- L  out  1  registered alarm level.
- L_rise  out  1  one-cycle pulse on the cycle `L` goes 0→1.
- L_fall  out  1  one-cycle pulse on the cycle `L` goes 1→0.
- evt_cnt  out  EVT_W  number of `L` rising events, saturating at all-ones.

## Operation
- Set condition: `D >= A`, unsigned.
- Clear condition: `D < A - H`, computed at WIDTH+1 bits.
  - If `H > A`, the clear threshold is taken as 0, so the clear condition is never true.
- `A` and `H` are used combinationally on every valid cycle and are not latched. A threshold change takes effect on the next valid sample; the run counter is not reset.
- Run counter `cnt` has width clog2(PERSIST+1).
- FSM states are LOW, ARM, HIGH and DISARM. All transitions occur only on cycles with `D_valid=1`; invalid cycles hold state, `cnt` and `L`.
  - LOW: set → ARM with cnt=1. If PERSIST=1, go directly to HIGH instead.
  - ARM: set → cnt+1; when cnt+1 = PERSIST → HIGH, cnt=0. Not set (including the band `A-H ≤ D < A`) → LOW, cnt=0.
  - HIGH: clear → DISARM with cnt=1. If PERSIST=1, go directly to LOW instead. Otherwise stay.
  - DISARM: clear → cnt+1; when cnt+1 = PERSIST → LOW, cnt=0. Not clear → HIGH, cnt=0.
- `L` = 1 in HIGH and DISARM, 0 in LOW and ARM.
- `evt_cnt` increments on each LOW/ARM→HIGH transition and stays at 2^EVT_W-1 once reached.
- Reset, asynchronous and usable at any time including mid-ARM or mid-DISARM:
  - state LOW, cnt 0, L 0, L_rise 0, L_fall 0, evt_cnt 0.

## Timing
- All outputs are registered. `L`, `L_rise` and `L_fall` change on the rising edge that consumes the PERSIST-th qualifying sample.
- Latency is one clock from that sample, plus PERSIST-1 earlier valid samples.
- With back-to-back valid samples, alarm assertion takes PERSIST cycles from the first qualifying sample.
- `L_rise` and `L_fall` are high for exactly one cycle and never in the same cycle.
- Back-to-back alarm/clear at PERSIST=1 is legal: a HIGH→LOW→HIGH sequence needs two valid samples.
- Reset deassertion needs no synchronisation inside the block. The first sample is accepted on the first edge after reset falls.

## Configuration
- STICKY_ALARM_EN
  - Defined:
    - Port `clr` exists.
    - In HIGH, the clear condition is ignored and DISARM is unreachable.
    - `clr=1` forces the next state to LOW with cnt=0 and `L_fall` pulsed, regardless of `D_valid`.
    - If `clr` and a set sample coincide, `clr` wins; the set sample is discarded.
  - Undefined:
    - No `clr` port.
    - Alarm clears only through DISARM as above.

## Test plan
Settings for all scenarios: WIDTH=5, PERSIST=3, A=25, H=3, so the clear threshold is 22. `D_valid` is high every cycle unless noted.

1. D=25,25,25 → `L` rises on the third edge; `L_rise` high for 1 cycle; evt_cnt=1.
2. D=25,24,25,25 → `L` stays 0. The 24 returns the FSM to LOW; no event.
3. From HIGH: D=23,22,21,21,21 → `L` stays 1 through the band samples; falls on the edge of the third 21; `L_fall` high for 1 cycle.
4. D=25,25, then reset asserted for 1 cycle, then D=25,25 → `L` stays 0; needs a third post-reset 25 to rise.
5. D=25 with `D_valid` toggling 1,0,1,0,1 → `L` rises on the edge of the third valid sample; invalid cycles hold cnt.
6. STICKY_ALARM_EN: reach HIGH, then D=0 ×5 → `L` stays 1; clr=1 → `L`=0 next edge. Then D=25 ×3 → `L` rises again; evt_cnt=2.
